// File: rtl/haz_scoreboard.sv
// -----------------------------------------------------------------------------
// haz_scoreboard
//
// Purpose:
//   Decode-stage hazard unit for an in-order pipeline. It tracks the
//   destination registers of the FWD_DEPTH instructions issued after decode and
//   drives three kinds of decision from them:
//     - forwarding selects for the two decode source operands
//       (youngest producer wins),
//     - a decode stall for load-use hazards and for branches whose operand
//       producer is still in the first execute stage,
//     - branch resolution, a redirect pulse and a multi-cycle flush window.
//   The backend never stalls. A stalled or flushed decode slot injects a bubble
//   into the tracked window.
//
// Parameters:
//   XLEN      - branch operand width
//   FWD_DEPTH - tracked/forwardable stages after decode (1..7)
//   LOAD_LAT  - first stage index at which load data can be forwarded
//               (1..FWD_DEPTH)
//   FLUSH_CYC - cycles FLUSH is held per redirect (>= 1)
//
// Ports:
//   clk_i            rising-edge clock
//   rst_n_i          asynchronous active-low reset
//   issue_valid_i    decode presents an instruction
//   issue_rd_i       destination register of the decode instruction
//   issue_we_i       decode instruction writes rd
//   issue_load_i     decode instruction is a load
//   rs1_i, rs2_i     decode source registers
//   rs1_used_i       decode instruction reads rs1
//   rs2_used_i       decode instruction reads rs2
//   branch_i         decode holds a conditional branch
//   jump_i           decode holds an unconditional jump
//   branch_type_i    BEQ/BNE/BLT/BGE/BLTU/BGEU (000..101)
//   branch_arg1_i    first branch operand, already forwarded
//   branch_arg2_i    second branch operand, already forwarded
//   fwd_a_sel_o      rs1 operand source: 0 = regfile, k = stage k result
//   fwd_b_sel_o      rs2 operand source: 0 = regfile, k = stage k result
//   stall_o          hold decode this cycle
//   flush_o          squash decode (redirect or flush window)
//   branch_taken_o   the conditional branch in decode resolves taken
//   stall_cnt_o      saturating count of stalled cycles
// -----------------------------------------------------------------------------
module haz_scoreboard #(
  parameter int XLEN      = 32,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 2,
  parameter int FLUSH_CYC = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             issue_valid_i,
  input  logic [4:0]       issue_rd_i,
  input  logic             issue_we_i,
  input  logic             issue_load_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic             rs1_used_i,
  input  logic             rs2_used_i,
  input  logic             branch_i,
  input  logic             jump_i,
  input  logic [2:0]       branch_type_i,
  input  logic [XLEN-1:0]  branch_arg1_i,
  input  logic [XLEN-1:0]  branch_arg2_i,
  output logic [SEL_W-1:0] fwd_a_sel_o,
  output logic [SEL_W-1:0] fwd_b_sel_o,
  output logic             stall_o,
  output logic             flush_o,
  output logic             branch_taken_o,
  output logic [31:0]      stall_cnt_o
);

  // Width of the flush countdown; it only ever holds FLUSH_CYC-1 down to 0.
  localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  // Branch type encodings
  localparam logic [2:0] BT_BEQ  = 3'b000;
  localparam logic [2:0] BT_BNE  = 3'b001;
  localparam logic [2:0] BT_BLT  = 3'b010;
  localparam logic [2:0] BT_BGE  = 3'b011;
  localparam logic [2:0] BT_BLTU = 3'b100;
  localparam logic [2:0] BT_BGEU = 3'b101;

  // ---------------------------------------------------------------------------
  // Branch condition evaluation. Types 110/111 are reserved and never taken.
  // ---------------------------------------------------------------------------
  function automatic logic branch_cond(input logic [2:0]      btype,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    logic res;
    case (btype)
      BT_BEQ:  res = (a == b);
      BT_BNE:  res = (a != b);
      BT_BLT:  res = ($signed(a) <  $signed(b));
      BT_BGE:  res = ($signed(a) >= $signed(b));
      BT_BLTU: res = (a <  b);
      BT_BGEU: res = (a >= b);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // In-flight window: entry k describes the instruction issued k cycles ago.
  // ---------------------------------------------------------------------------
  logic [FWD_DEPTH:1] vld_q, vld_d;
  logic [FWD_DEPTH:1] we_q,  we_d;
  logic [FWD_DEPTH:1] ld_q,  ld_d;
  logic [4:0]         rd_q [FWD_DEPTH:1];
  logic [4:0]         rd_d [FWD_DEPTH:1];

  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [31:0]        stall_cnt_q, stall_cnt_d;

  // Youngest-producer lookup results per source
  logic [SEL_W-1:0]   sel_a_s, sel_b_s;
  logic               ld_a_s,  ld_b_s;

  // Hazard / control intermediates
  logic               stall_raw_s;
  logic               flushing_s;
  logic               cond_s;
  logic               taken_s;
  logic               redirect_s;
  logic               stall_s;
  logic               flush_s;
  logic               issue_s;

  // Youngest matching producer for rs1. Scanning from the oldest entry down
  // lets the last assignment (smallest k) win.
  always_comb begin
    sel_a_s = '0;
    ld_a_s  = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (vld_q[k] && we_q[k] && (rd_q[k] == rs1_i) &&
          (rs1_i != 5'd0) && rs1_used_i) begin
        sel_a_s = SEL_W'(k);
        ld_a_s  = ld_q[k];
      end else begin
        sel_a_s = sel_a_s;
        ld_a_s  = ld_a_s;
      end
    end
  end

  // Youngest matching producer for rs2, same scheme as rs1.
  always_comb begin
    sel_b_s = '0;
    ld_b_s  = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (vld_q[k] && we_q[k] && (rd_q[k] == rs2_i) &&
          (rs2_i != 5'd0) && rs2_used_i) begin
        sel_b_s = SEL_W'(k);
        ld_b_s  = ld_q[k];
      end else begin
        sel_b_s = sel_b_s;
        ld_b_s  = ld_b_s;
      end
    end
  end

  // Stall, branch resolution, redirect and flush decisions.
  always_comb begin
    // A load whose youngest producer sits before LOAD_LAT has no data yet.
    // A branch cannot use a result that is still being computed in stage 1.
    stall_raw_s = (ld_a_s && (sel_a_s < SEL_W'(LOAD_LAT))) ||
                  (ld_b_s && (sel_b_s < SEL_W'(LOAD_LAT))) ||
                  (branch_i && ((sel_a_s == SEL_W'(1)) ||
                                (sel_b_s == SEL_W'(1))));
    flushing_s  = (flush_cnt_q != '0);
    cond_s      = branch_cond(branch_type_i, branch_arg1_i, branch_arg2_i);

    // An instruction sitting in decode during a flush window is already
    // squashed, so it neither stalls nor redirects.
    stall_s     = stall_raw_s && !flushing_s;
    taken_s     = branch_i && cond_s && !stall_raw_s && !flushing_s;
    redirect_s  = taken_s || (jump_i && !stall_raw_s && !flushing_s);
    flush_s     = redirect_s || flushing_s;
    issue_s     = issue_valid_i && !stall_s && !flush_s;
  end

  // Next state of the window, flush countdown and stall counter.
  always_comb begin
    vld_d = '0;
    we_d  = '0;
    ld_d  = '0;
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      rd_d[k] = 5'd0;
    end

    // Stage 1 takes the decode instruction or a bubble.
    if (issue_s) begin
      vld_d[1] = 1'b1;
      we_d[1]  = issue_we_i;
      ld_d[1]  = issue_load_i;
      rd_d[1]  = issue_rd_i;
    end else begin
      vld_d[1] = 1'b0;
      we_d[1]  = 1'b0;
      ld_d[1]  = 1'b0;
      rd_d[1]  = 5'd0;
    end

    // Older stages always advance; the last entry simply drops off.
    for (int k = 2; k <= FWD_DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      we_d[k]  = we_q[k-1];
      ld_d[k]  = ld_q[k-1];
      rd_d[k]  = rd_q[k-1];
    end

    // The redirect cycle itself is the first flush cycle, hence FLUSH_CYC-1.
    if (redirect_s) begin
      flush_cnt_d = CNT_W'(FLUSH_CYC - 1);
    end else if (flushing_s) begin
      flush_cnt_d = flush_cnt_q - CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end

    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers; reset empties the window and aborts stall/flush activity.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q       <= '0;
      we_q        <= '0;
      ld_q        <= '0;
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        rd_q[k] <= 5'd0;
      end
      flush_cnt_q <= '0;
      stall_cnt_q <= 32'd0;
    end else begin
      vld_q       <= vld_d;
      we_q        <= we_d;
      ld_q        <= ld_d;
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        rd_q[k] <= rd_d[k];
      end
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Output drive. FLUSH and STALL are held low while reset is asserted even if
  // a jump or branch is presented; BRANCH_TAKEN still reflects the inputs.
  assign fwd_a_sel_o    = sel_a_s;
  assign fwd_b_sel_o    = sel_b_s;
  assign stall_o        = stall_s && rst_n_i;
  assign flush_o        = flush_s && rst_n_i;
  assign branch_taken_o = taken_s;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: doc/haz_scoreboard.md
HAZ_SCOREBOARD -- requirements
Module: haz_scoreboard

Interface
REQ-001 SHALL provide parameter XLEN, default 32, branch operand width.
REQ-002 SHALL provide parameter FWD_DEPTH, default 2, in-flight stages tracked and forwardable after decode (1..7).
REQ-003 SHALL provide parameter LOAD_LAT, default 2, stage index at which load data first becomes forwardable (1..FWD_DEPTH).
REQ-004 SHALL provide parameter FLUSH_CYC, default 2, cycles FLUSH is held per redirect (>=1).
REQ-005 SHALL use derived width SEL_W = clog2(FWD_DEPTH+1).
REQ-006 CLK  in  1  single clock, rising edge.
REQ-007 RST_N  in  1  reset, asynchronous, active-low.
REQ-008 ISSUE_VALID  in  1  decode instruction is presented this cycle.
REQ-009 ISSUE_RD / ISSUE_WE / ISSUE_LOAD  in  5/1/1  destination, writes-rd, is-load.
REQ-010 RS1 / RS2  in  5 each  decode source registers; RS1_USED / RS2_USED  in  1 each  source is read.
REQ-011 BRANCH / JUMP  in  1 each  decode holds conditional branch / jump.
REQ-012 BRANCH_TYPE  in  3  000 BEQ, 001 BNE, 010 BLT, 011 BGE, 100 BLTU, 101 BGEU.
REQ-013 BRANCH_ARG1 / BRANCH_ARG2  in  XLEN each  already-forwarded branch operands.
REQ-014 FWD_A_SEL / FWD_B_SEL  out  SEL_W each  0 = regfile, k = stage k result.
REQ-015 STALL / FLUSH / BRANCH_TAKEN  out  1 each; STALL_CNT  out  32  stall cycle counter.

Function
REQ-016 SHALL hold entries E[1..FWD_DEPTH] of {valid, rd, we, load}; E[k] = instruction issued k cycles ago.
REQ-017 Every cycle SHALL shift E[k] -> E[k+1]; E[FWD_DEPTH] retires; backend never stalls.
REQ-018 E[1] SHALL load {1, ISSUE_RD, ISSUE_WE, ISSUE_LOAD} when ISSUE_VALID && !STALL && !FLUSH, else a bubble (valid=0).
REQ-019 Match(k,rs) SHALL be E[k].valid && E[k].we && E[k].rd == rs && rs != 0 && RSx_USED.
REQ-020 FWD_x_SEL SHALL be the smallest k with Match(k,rs) (youngest wins), 0 if none; combinational, zero latency.
REQ-021 Load-use: STALL SHALL assert if the youngest match is a load with k < LOAD_LAT.
REQ-022 Branch-operand hazard: STALL SHALL assert if BRANCH and youngest match for a used source has k == 1 (result not yet computed).
REQ-023 STALL SHALL be forced 0 while FLUSH is high.
REQ-024 Condition SHALL use signed compare for BLT/BGE, unsigned for BLTU/BGEU; types 110/111 are never taken.
REQ-025 BRANCH_TAKEN SHALL be BRANCH && condition && !STALL; redirect = BRANCH_TAKEN || (JUMP && !STALL).
REQ-026 FLUSH SHALL be redirect || (flush_cnt != 0); on redirect flush_cnt <= FLUSH_CYC-1; decrements to 0 otherwise.
REQ-027 Redirect while flush_cnt != 0 SHALL be ignored (instruction is already being flushed).
REQ-028 STALL_CNT SHALL increment each cycle STALL=1, saturating at 0xFFFF_FFFF.
REQ-029 Outputs for sources with RSx_USED=0 SHALL be 0 and SHALL NOT cause STALL.

Reset
REQ-030 RST_N low SHALL immediately clear all entries, flush_cnt, STALL_CNT; FWD_x_SEL=0, STALL=0, FLUSH=0 while low, BRANCH_TAKEN=0 unless BRANCH inputs present.
REQ-031 Reset mid-flush or mid-stall SHALL abort it; first cycle after release behaves as empty pipeline.

Verification (FWD_DEPTH=2, LOAD_LAT=2, FLUSH_CYC=2)
REQ-032 Issue ADD x5; next cycle RS1=5 -> FWD_A_SEL=1, STALL=0; cycle after RS2=5 -> FWD_B_SEL=2; cycle after -> 0.
REQ-033 Issue LW x7; next cycle RS1=7 -> STALL=1, E[1] bubble, STALL_CNT=1; following cycle FWD_A_SEL=2, STALL=0.
REQ-034 Issue ADD x0; next cycle RS1=0 -> FWD_A_SEL=0, STALL=0; two writers of x9 at E[1],E[2] -> FWD_A_SEL=1.
REQ-035 BEQ ARG1=ARG2=0x10 -> BRANCH_TAKEN=1, FLUSH=1 for 2 cycles, ISSUE_VALID ignored; BLTU 0xFFFF_FFFF<1 -> not taken, BLT -> taken.
REQ-036 ADD x3 issued, then BNE RS1=3 -> STALL=1, BRANCH_TAKEN=0; next cycle FWD_A_SEL=2, branch resolves.
REQ-037 RST_N low during FLUSH with STALL_CNT=5 -> FLUSH=0, STALL_CNT=0, all FWD_x_SEL=0 immediately.
